led_seq_ctrl: RTL and testbench
===============================

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, ROM address width.
REQ-002 SHALL have parameter DATA_W, default 8, ROM data and LED width.
REQ-003 SHALL have parameter DIV_W, default 24, step-divider width.
REQ-004 SHALL have port CLK  input  1  single system clock; all state updates on rising edge.
REQ-005 SHALL have port RESET  input  1  synchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin playback.
REQ-007 SHALL have port stop  input  1  one-cycle request to abort playback.
REQ-008 SHALL have port dir  input  1  0 = ascending addresses, 1 = descending.
REQ-009 SHALL have port loop  input  1  1 = wrap and continue at range end, 0 = one-shot.
REQ-010 SHALL have port div_val  input  DIV_W  hold time per step, in cycles minus one.
REQ-011 SHALL have port addr_lo  input  ADDR_W  first address of the playback range.
REQ-012 SHALL have port addr_hi  input  ADDR_W  last address of the playback range.
REQ-013 SHALL have port rom_addr  output  ADDR_W  address presented to the external synchronous ROM.
REQ-014 SHALL have port rom_rd  output  1  high in the cycle rom_addr is to be sampled.
REQ-015 SHALL have port rom_q  input  DATA_W  ROM data, valid exactly one cycle after the rom_rd cycle.
REQ-016 SHALL have port led  output  DATA_W  registered pattern output.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.
REQ-018 SHALL have port done  output  1  one-cycle pulse at the end of one-shot playback.

Function
REQ-019 SHALL implement FSM states IDLE, FETCH, LATCH and HOLD.
REQ-020 In IDLE, a start with addr_lo <= addr_hi and stop low SHALL latch dir, loop, div_val, addr_lo and addr_hi, load rom_addr with addr_lo (dir=0) or addr_hi (dir=1), and enter FETCH next cycle.
REQ-021 A start in IDLE with addr_lo > addr_hi SHALL be ignored: state stays IDLE, outputs unchanged.
REQ-022 If start and stop are both high in IDLE, the block SHALL stay in IDLE.
REQ-023 FETCH SHALL last one cycle with rom_rd=1, then go to LATCH; rom_rd SHALL be 0 in all other states.
REQ-024 LATCH SHALL register rom_q into led, load the hold counter with the latched div_val, and go to HOLD.
REQ-025 HOLD SHALL decrement the counter each cycle and leave HOLD in the cycle the counter reads 0, so HOLD lasts div_val+1 cycles.
REQ-026 The step period SHALL be div_val+3 cycles, from rom_rd high to the next rom_rd high.
REQ-027 On leaving HOLD at a non-final address, rom_addr SHALL step by +1 (dir=0) or -1 (dir=1), and the FSM SHALL enter FETCH.
REQ-028 The final address SHALL be addr_hi (dir=0) or addr_lo (dir=1).
REQ-029 At the final address with loop=1, rom_addr SHALL reload the first address and the FSM SHALL enter FETCH.
REQ-030 At the final address with loop=0, done SHALL pulse for one cycle and the FSM SHALL enter IDLE.
REQ-031 When addr_lo == addr_hi, the range SHALL be a single entry: one step, then loop (re-fetch of the same address) or done.
REQ-032 Address arithmetic SHALL be modulo 2^ADDR_W; in-range operation never wraps past 0 or 2^ADDR_W-1.
REQ-033 A stop in FETCH, LATCH or HOLD SHALL force IDLE next cycle, with the following effects: led holds its value, rom_addr holds, no done pulse, and any LATCH update in that same cycle still completes.
REQ-034 A start while busy SHALL be ignored.
REQ-035 Changes to the configuration inputs while busy SHALL have no effect until the next accepted start.

Reset
REQ-036 With RESET low at a clock edge, the block SHALL set state=IDLE, led=0, rom_addr=0, rom_rd=0, busy=0, done=0 and hold counter=0, with priority over all other inputs.
REQ-037 Reset asserted mid-playback SHALL abort with no done pulse; after release, the block SHALL require a new start.

Verification
REQ-038 Bench SHALL cover: reset, then addr_lo=0, addr_hi=3, dir=0, loop=0, div_val=2, start -> rom_rd at addresses 0,1,2,3 spaced 5 cycles, led = ROM[0..3] each one cycle after rom_rd, done pulse once, busy drops.
REQ-039 Bench SHALL cover: addr_lo=4, addr_hi=6, dir=1, loop=1, div_val=0 -> address sequence 6,5,4,6,5,... every 3 cycles, done never asserted.
REQ-040 Bench SHALL cover: addr_lo=7, addr_hi=7, loop=0, start -> single fetch of address 7, led=ROM[7], done 3+div_val cycles after start acceptance.
REQ-041 Bench SHALL cover: addr_lo=9, addr_hi=2, start -> busy stays 0, rom_rd never asserts, led unchanged.
REQ-042 Bench SHALL cover: stop during HOLD of step 2 -> IDLE next cycle, led keeps ROM[step 2], no done; a start in the same cycle as stop has no effect.
REQ-043 Bench SHALL cover: RESET low during HOLD -> all outputs 0 next cycle; a new start replays from the first address.

Source files
------------

// File: rtl/led_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : led_seq_ctrl
//  Purpose  : Plays a range of LED patterns out of an external synchronous
//             ROM.  Each step fetches one ROM word, registers it onto the LED
//             outputs and holds it for a programmable number of cycles. The
//             range is walked up or down and either wraps (loop) or stops
//             with a one-cycle done pulse (one-shot).
//
//  Ports    : CLK      - system clock, all state changes on the rising edge
//             RESET    - synchronous, active-low reset
//             start    - one-cycle request to begin playback (IDLE only)
//             stop     - one-cycle request to abort playback
//             dir      - 0 = ascending addresses, 1 = descending
//             loop     - 1 = wrap at range end, 0 = one-shot
//             div_val  - hold time per step, in cycles minus one
//             addr_lo  - first address of the playback range
//             addr_hi  - last address of the playback range
//             rom_addr - address presented to the ROM
//             rom_rd   - high in the cycle rom_addr is to be sampled
//             rom_q    - ROM data, valid one cycle after the rom_rd cycle
//             led      - registered pattern output
//             busy     - high in every state except IDLE
//             done     - one-cycle pulse at the end of one-shot playback
//
//  Revision : 1.0  initial release
// ============================================================================
module led_seq_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int DIV_W  = 24
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic              stop,
    input  logic              dir,
    input  logic              loop,
    input  logic [DIV_W-1:0]  div_val,
    input  logic [ADDR_W-1:0] addr_lo,
    input  logic [ADDR_W-1:0] addr_hi,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rd,
    input  logic [DATA_W-1:0] rom_q,
    output logic [DATA_W-1:0] led,
    output logic              busy,
    output logic              done
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_LATCH = 2'd2;
    localparam logic [1:0] c_HOLD  = 2'd3;

    localparam logic [ADDR_W-1:0] c_ADDR_ONE = ADDR_W'(1);
    localparam logic [DIV_W-1:0]  c_DIV_ONE  = DIV_W'(1);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]        state_q,    state_d;
    logic [DATA_W-1:0] led_q,      led_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [DIV_W-1:0]  cnt_q,      cnt_d;
    logic              done_q,     done_d;

    // Configuration captured at an accepted start; the live inputs are
    // ignored for the rest of the run.
    logic              dir_q,      dir_d;
    logic              loop_q,     loop_d;
    logic [DIV_W-1:0]  div_q,      div_d;
    logic [ADDR_W-1:0] lo_q,       lo_d;
    logic [ADDR_W-1:0] hi_q,       hi_d;

    // ------------------------------------------------------------------------
    // Address helpers (all based on the latched configuration)
    // ------------------------------------------------------------------------
    logic              w_at_final;
    logic [ADDR_W-1:0] w_first_addr;
    logic [ADDR_W-1:0] w_step_addr;
    logic              w_start_ok;

    // The last address of the walk depends on direction: ascending ends at
    // the high bound, descending ends at the low bound.
    assign w_at_final   = dir_q ? (rom_addr_q == lo_q) : (rom_addr_q == hi_q);
    assign w_first_addr = dir_q ? hi_q : lo_q;
    // Modulo arithmetic; a legal range never steps past either end.
    assign w_step_addr  = dir_q ? (rom_addr_q - c_ADDR_ONE)
                                : (rom_addr_q + c_ADDR_ONE);

    // An empty (inverted) range or a simultaneous stop rejects the start.
    assign w_start_ok   = start && !stop && (addr_lo <= addr_hi);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        led_d      = led_q;
        rom_addr_d = rom_addr_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        dir_d      = dir_q;
        loop_d     = loop_q;
        div_d      = div_q;
        lo_d       = lo_q;
        hi_d       = hi_q;

        case (state_q)
            c_IDLE: begin
                if (w_start_ok) begin
                    dir_d      = dir;
                    loop_d     = loop;
                    div_d      = div_val;
                    lo_d       = addr_lo;
                    hi_d       = addr_hi;
                    rom_addr_d = dir ? addr_hi : addr_lo;
                    state_d    = c_FETCH;
                end
            end

            c_FETCH: begin
                // rom_rd is asserted for this single cycle.
                state_d = stop ? c_IDLE : c_LATCH;
            end

            c_LATCH: begin
                // ROM data arrives now; the capture completes even when a
                // stop is seen in the same cycle.
                led_d   = rom_q;
                cnt_d   = div_q;
                state_d = stop ? c_IDLE : c_HOLD;
            end

            c_HOLD: begin
                if (stop) begin
                    // Abort: LED and address freeze, no done pulse.
                    state_d = c_IDLE;
                end else if (cnt_q == '0) begin
                    if (!w_at_final) begin
                        rom_addr_d = w_step_addr;
                        state_d    = c_FETCH;
                    end else if (loop_q) begin
                        rom_addr_d = w_first_addr;
                        state_d    = c_FETCH;
                    end else begin
                        done_d     = 1'b1;
                        state_d    = c_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - c_DIV_ONE;
                end
            end

            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers with synchronous active-low reset
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q    <= c_IDLE;
            led_q      <= '0;
            rom_addr_q <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            dir_q      <= 1'b0;
            loop_q     <= 1'b0;
            div_q      <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
        end else begin
            state_q    <= state_d;
            led_q      <= led_d;
            rom_addr_q <= rom_addr_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            dir_q      <= dir_d;
            loop_q     <= loop_d;
            div_q      <= div_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rom_addr = rom_addr_q;
    assign rom_rd   = (state_q == c_FETCH);
    assign led      = led_q;
    assign busy     = (state_q != c_IDLE);
    assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_led_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_seq_ctrl
//  Purpose  : Directed self-checking bench for led_seq_ctrl with a small
//             synchronous ROM model (ROM[a] = {3'b101, a}).
//  Revision : 1.0  initial release
// ============================================================================
module tb_led_seq_ctrl;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int DIV_W  = 24;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              start;
    logic              stop;
    logic              dir;
    logic              loop;
    logic [DIV_W-1:0]  div_val;
    logic [ADDR_W-1:0] addr_lo;
    logic [ADDR_W-1:0] addr_hi;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_rd;
    logic [DATA_W-1:0] rom_q = '0;
    logic [DATA_W-1:0] led;
    logic              busy;
    logic              done;

    int errors = 0;
    int checks = 0;

    led_seq_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DIV_W  (DIV_W)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .start    (start),
        .stop     (stop),
        .dir      (dir),
        .loop     (loop),
        .div_val  (div_val),
        .addr_lo  (addr_lo),
        .addr_hi  (addr_hi),
        .rom_addr (rom_addr),
        .rom_rd   (rom_rd),
        .rom_q    (rom_q),
        .led      (led),
        .busy     (busy),
        .done     (done)
    );

    always #5 CLK = ~CLK;

    // Synchronous ROM: data valid in the cycle after the rom_rd cycle.
    always @(posedge CLK) begin
        if (rom_rd) rom_q <= {3'b101, rom_addr};
    end

    function automatic logic [DATA_W-1:0] rom_val(input int a);
        logic [ADDR_W-1:0] a5;
        a5 = a[ADDR_W-1:0];
        return {3'b101, a5};
    endfunction

    // Advance one clock edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start pulse; returns 1 time unit after the accepting edge.
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    int seq2 [7] = '{6, 5, 4, 6, 5, 4, 6};

    initial begin
        RESET   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        dir     = 1'b0;
        loop    = 1'b0;
        div_val = '0;
        addr_lo = '0;
        addr_hi = '0;

        // ---------------- reset ----------------
        tick();
        tick();
        chk("rst_led",      led,      0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_rom_rd",   rom_rd,   0);
        chk("rst_busy",     busy,     0);
        chk("rst_done",     done,     0);
        RESET = 1'b1;
        tick();

        // ---------------- one-shot ascending 0..3, div=2 ----------------
        addr_lo = 5'd0; addr_hi = 5'd3; dir = 1'b0; loop = 1'b0; div_val = 24'd2;
        pulse_start();
        chk("t1_busy", busy, 1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t1_rd%0d", k),   rom_rd,   1);
            chk($sformatf("t1_addr%0d", k), rom_addr, k);
            chk($sformatf("t1_done_f%0d", k), done, 0);
            tick();
            chk($sformatf("t1_rd_lat%0d", k), rom_rd, 0);
            tick();
            chk($sformatf("t1_led%0d", k), led, rom_val(k));
            chk($sformatf("t1_rd_hold%0d", k), rom_rd, 0);
            tick();
            tick();
            chk($sformatf("t1_done_h%0d", k), done, 0);
            tick();
        end
        chk("t1_done",      done, 1);
        chk("t1_busy_end",  busy, 0);
        chk("t1_rd_end",    rom_rd, 0);
        chk("t1_led_end",   led,  rom_val(3));
        tick();
        chk("t1_done_once", done, 0);

        // ---------------- loop descending 6..4, div=0 ----------------
        addr_lo = 5'd4; addr_hi = 5'd6; dir = 1'b1; loop = 1'b1; div_val = 24'd0;
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("t2_rd%0d", i),   rom_rd,   1);
            chk($sformatf("t2_addr%0d", i), rom_addr, seq2[i]);
            tick();
            chk($sformatf("t2_done_a%0d", i), done, 0);
            chk($sformatf("t2_rd_lat%0d", i), rom_rd, 0);
            tick();
            chk($sformatf("t2_led%0d", i), led, rom_val(seq2[i]));
            chk($sformatf("t2_done_b%0d", i), done, 0);
            tick();
        end
        // Now in FETCH of address 5; stop ends the run, address holds.
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t2_stop_busy", busy,     0);
        chk("t2_stop_addr", rom_addr, 5);
        chk("t2_stop_done", done,     0);
        chk("t2_stop_led",  led,      rom_val(6));

        // ---------------- single entry 7..7, one-shot, div=1 ----------------
        addr_lo = 5'd7; addr_hi = 5'd7; dir = 1'b0; loop = 1'b0; div_val = 24'd1;
        pulse_start();
        chk("t3_rd",   rom_rd,   1);
        chk("t3_addr", rom_addr, 7);
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk($sformatf("t3_nodone%0d", c), done, 0);
        end
        chk("t3_led",  led, rom_val(7));
        tick();
        chk("t3_done", done, 1);
        chk("t3_idle", busy, 0);
        tick();
        chk("t3_done_once", done, 0);

        // ---------------- inverted range is rejected ----------------
        addr_lo = 5'd9; addr_hi = 5'd2; dir = 1'b0; loop = 1'b0; div_val = 24'd0;
        pulse_start();
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("t4_busy%0d", c), busy,   0);
            chk($sformatf("t4_rd%0d", c),   rom_rd, 0);
            chk($sformatf("t4_led%0d", c),  led,    rom_val(7));
            tick();
        end
        chk("t4_addr", rom_addr, 7);

        // start and stop together in IDLE: stays IDLE
        addr_lo = 5'd1; addr_hi = 5'd2;
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("t4_ss_busy", busy, 0);

        // ---------------- stop during HOLD of step 2 ----------------
        addr_lo = 5'd10; addr_hi = 5'd14; dir = 1'b0; loop = 1'b0; div_val = 24'd3;
        pulse_start();
        chk("t5_addr0", rom_addr, 10);
        tick();
        tick();
        // HOLD of step 1: config change and a start while busy do nothing
        addr_lo = 5'd0; addr_hi = 5'd1; dir = 1'b1; div_val = 24'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_busy_mid", busy, 1);
        tick();
        tick();
        tick();
        chk("t5_rd1",   rom_rd,   1);
        chk("t5_addr1", rom_addr, 11);
        tick();
        tick();
        chk("t5_led1",  led, rom_val(11));
        chk("t5_hold",  busy, 1);
        addr_lo = 5'd20; addr_hi = 5'd22; dir = 1'b0;
        stop = 1'b1; start = 1'b1;
        tick();
        stop = 1'b0; start = 1'b0;
        chk("t5_stop_busy", busy,     0);
        chk("t5_stop_led",  led,      rom_val(11));
        chk("t5_stop_addr", rom_addr, 11);
        chk("t5_stop_done", done,     0);
        tick();
        chk("t5_after_busy", busy, 0);
        chk("t5_after_done", done, 0);
        chk("t5_after_rd",   rom_rd, 0);

        // ---------------- reset during HOLD, then replay ----------------
        addr_lo = 5'd1; addr_hi = 5'd3; dir = 1'b0; loop = 1'b1; div_val = 24'd2;
        pulse_start();
        tick();
        tick();
        chk("t6_led_pre", led,  rom_val(1));
        chk("t6_busy_pre", busy, 1);
        RESET = 1'b0;
        tick();
        chk("t6_rst_led",  led,      0);
        chk("t6_rst_addr", rom_addr, 0);
        chk("t6_rst_rd",   rom_rd,   0);
        chk("t6_rst_busy", busy,     0);
        chk("t6_rst_done", done,     0);
        RESET = 1'b1;
        tick();
        tick();
        chk("t6_idle_busy", busy, 0);
        chk("t6_idle_done", done, 0);
        pulse_start();
        chk("t6_replay_rd",   rom_rd,   1);
        chk("t6_replay_addr", rom_addr, 1);
        tick();
        tick();
        chk("t6_replay_led",  led, rom_val(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
